// File: rtl/issue_scheduler.sv
// Binds ready RS entries to idle ALUs round-robin, times each op by ALUOp, grants the CDB round-robin.
// Issue visible 1 cycle after sampling; a finished ALU holds its result in WB until it wins the CDB.
module issue_scheduler #(
  parameter int RS_ENTRIES = 8,
  parameter int NUM_ALU    = 2,
  parameter int ALUOP_BITS = 3,
  parameter int DELAY_LAT  = 4,
  parameter int EXP_LAT    = 8,
  localparam int IDXW      = $clog2(RS_ENTRIES),
  localparam int AW        = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush,
  input  logic [RS_ENTRIES-1:0]                  rdy_vec,
  input  logic [RS_ENTRIES-1:0][ALUOP_BITS-1:0]  rs_aluop,
  output logic [NUM_ALU-1:0]                     issue_valid,
  output logic [NUM_ALU-1:0][IDXW-1:0]           issue_idx,
  output logic [NUM_ALU-1:0][ALUOP_BITS-1:0]     issue_aluop,
  output logic [NUM_ALU-1:0]                     alu_busy,
  output logic                                   cdb_valid,
  output logic [AW-1:0]                          cdb_alu,
  output logic [IDXW-1:0]                        cdb_idx
);

  localparam int MAXLAT = (DELAY_LAT > EXP_LAT) ? DELAY_LAT : EXP_LAT;
  localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
  localparam logic [ALUOP_BITS-1:0] OP_DELAY = ALUOP_BITS'(5);
  localparam logic [ALUOP_BITS-1:0] OP_EXP   = ALUOP_BITS'(7);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} alu_state_t;

  alu_state_t            state_q [NUM_ALU];
  alu_state_t            state_d [NUM_ALU];
  logic [CW-1:0]         cnt_q   [NUM_ALU];
  logic [CW-1:0]         cnt_d   [NUM_ALU];
  logic [IDXW-1:0]       tag_q   [NUM_ALU];
  logic [IDXW-1:0]       tag_d   [NUM_ALU];

  logic [RS_ENTRIES-1:0] issued_mask, mask_d, eligible;
  logic [IDXW-1:0]       issue_ptr, ptr_d;
  logic [AW-1:0]         cdb_ptr, cptr_d;

  logic [NUM_ALU-1:0]                 iv_d;
  logic [NUM_ALU-1:0][IDXW-1:0]       iidx_d;
  logic [NUM_ALU-1:0][ALUOP_BITS-1:0] iop_d;
  logic                               cv_d;
  logic [AW-1:0]                      calu_d;
  logic [IDXW-1:0]                    cidx_d;

  // EXEC count is loaded with LAT-1 so a 1-cycle op leaves EXEC at the next edge.
  function automatic logic [CW-1:0] lat_m1(input logic [ALUOP_BITS-1:0] op);
    if (op == OP_DELAY)    return CW'(DELAY_LAT - 1);
    else if (op == OP_EXP) return CW'(EXP_LAT - 1);
    else                   return '0;
  endfunction

  assign eligible = rdy_vec & ~issued_mask;

  always_comb begin
    for (int k = 0; k < NUM_ALU; k++) alu_busy[k] = (state_q[k] != S_IDLE);
  end

  always_comb begin
    logic [NUM_ALU-1:0] free;
    logic               granted;
    logic               placed;
    int                 p;
    int                 g;
    free    = '0;
    granted = 1'b0;
    placed  = 1'b0;
    p       = 0;
    g       = 0;
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    mask_d  = issued_mask & rdy_vec;
    ptr_d   = issue_ptr;
    cptr_d  = cdb_ptr;
    iv_d    = '0;
    iidx_d  = '0;
    iop_d   = '0;
    cv_d    = 1'b0;
    calu_d  = '0;
    cidx_d  = '0;

    for (int k = 0; k < NUM_ALU; k++) begin
      free[k] = (state_q[k] == S_IDLE);
      if (state_q[k] == S_EXEC) begin
        if (cnt_q[k] == '0) state_d[k] = S_WB;
        else                cnt_d[k]   = cnt_q[k] - CW'(1);
      end
    end

    for (int j = 0; j < NUM_ALU; j++) begin
      g = int'(cdb_ptr) + j;
      if (g >= NUM_ALU) g = g - NUM_ALU;
      if (!granted && state_q[g] == S_WB) begin
        granted    = 1'b1;
        cv_d       = 1'b1;
        calu_d     = AW'(g);
        cidx_d     = tag_q[g];
        state_d[g] = S_IDLE;
        cptr_d     = AW'((g + 1) % NUM_ALU);
      end
    end

    // Free is sampled from the registered state, so an ALU granted this edge cannot also be issued.
    for (int j = 0; j < RS_ENTRIES; j++) begin
      p = int'(issue_ptr) + j;
      if (p >= RS_ENTRIES) p = p - RS_ENTRIES;
      placed = 1'b0;
      if (eligible[p]) begin
        for (int k = 0; k < NUM_ALU; k++) begin
          if (!placed && free[k]) begin
            placed     = 1'b1;
            free[k]    = 1'b0;
            iv_d[k]    = 1'b1;
            iidx_d[k]  = IDXW'(p);
            iop_d[k]   = rs_aluop[p];
            state_d[k] = S_EXEC;
            cnt_d[k]   = lat_m1(rs_aluop[p]);
            tag_d[k]   = IDXW'(p);
          end
        end
        if (placed) begin
          mask_d[p] = 1'b1;
          ptr_d     = IDXW'((p + 1) % RS_ENTRIES);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_ALU; k++) begin
        state_q[k] <= S_IDLE;
        cnt_q[k]   <= '0;
        tag_q[k]   <= '0;
      end
      issued_mask <= '0;
      issue_ptr   <= '0;
      cdb_ptr     <= '0;
      issue_valid <= '0;
      issue_idx   <= '0;
      issue_aluop <= '0;
      cdb_valid   <= 1'b0;
      cdb_alu     <= '0;
      cdb_idx     <= '0;
    end else if (flush) begin
      // Squash: any WB result is dropped without reaching the CDB.
      for (int k = 0; k < NUM_ALU; k++) begin
        state_q[k] <= S_IDLE;
        cnt_q[k]   <= '0;
        tag_q[k]   <= '0;
      end
      issued_mask <= '0;
      issue_ptr   <= '0;
      cdb_ptr     <= '0;
      issue_valid <= '0;
      issue_idx   <= '0;
      issue_aluop <= '0;
      cdb_valid   <= 1'b0;
      cdb_alu     <= '0;
      cdb_idx     <= '0;
    end else begin
      for (int k = 0; k < NUM_ALU; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
        tag_q[k]   <= tag_d[k];
      end
      issued_mask <= mask_d;
      issue_ptr   <= ptr_d;
      cdb_ptr     <= cptr_d;
      issue_valid <= iv_d;
      issue_idx   <= iidx_d;
      issue_aluop <= iop_d;
      cdb_valid   <= cv_d;
      cdb_alu     <= calu_d;
      cdb_idx     <= cidx_d;
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus randomized traffic against a timestamp-based reference.
module tb_issue_scheduler;
  localparam int RS  = 8;
  localparam int NA  = 2;
  localparam int OPB = 3;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    flush = 1'b0;
  logic [RS-1:0]           rdy_vec = '0;
  logic [RS-1:0][OPB-1:0]  rs_aluop = '0;
  logic [NA-1:0]           issue_valid;
  logic [NA-1:0][2:0]      issue_idx;
  logic [NA-1:0][OPB-1:0]  issue_aluop;
  logic [NA-1:0]           alu_busy;
  logic                    cdb_valid;
  logic [0:0]              cdb_alu;
  logic [2:0]              cdb_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int cdb_log[$];
  int iss_log[$];

  // Reference state: an ALU is busy from issue until its grant; ready_at is the first edge it may win the CDB.
  bit            m_busy[NA];
  int            m_ready[NA];
  int            m_tag[NA];
  bit [RS-1:0]   m_mask;
  int            m_iptr, m_cptr, m_t;
  logic [NA-1:0] e_iv, e_busy;
  int            e_idx[NA];
  int            e_op[NA];
  bit            e_cv;
  int            e_calu, e_cidx;

  issue_scheduler #(.RS_ENTRIES(RS), .NUM_ALU(NA), .ALUOP_BITS(OPB), .DELAY_LAT(4), .EXP_LAT(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .rdy_vec(rdy_vec), .rs_aluop(rs_aluop),
    .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_aluop(issue_aluop),
    .alu_busy(alu_busy), .cdb_valid(cdb_valid), .cdb_alu(cdb_alu), .cdb_idx(cdb_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cdb_valid) cdb_log.push_back(int'(cdb_alu) * 16 + int'(cdb_idx));
    for (int k = 0; k < NA; k++) if (issue_valid[k]) iss_log.push_back(int'(issue_idx[k]));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; flush = 1'b0; rdy_vec = '0; rs_aluop = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cdb_log.delete();
    iss_log.delete();
  endtask

  function automatic int op_lat(int op);
    if (op == 5) return 4;
    if (op == 7) return 8;
    return 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NA; k++) begin m_busy[k] = 0; m_ready[k] = 0; m_tag[k] = 0; end
    m_mask = '0; m_iptr = 0; m_cptr = 0; m_t = 0;
  endtask

  task automatic model_edge();
    bit          fr[NA];
    bit [RS-1:0] elig;
    int          g, a, e, st;
    e_iv = '0; e_cv = 0; e_calu = 0; e_cidx = 0;
    for (int k = 0; k < NA; k++) begin e_idx[k] = 0; e_op[k] = 0; end
    if (flush) begin
      for (int k = 0; k < NA; k++) m_busy[k] = 0;
      m_mask = '0; m_iptr = 0; m_cptr = 0;
    end else begin
      g = -1;
      for (int j = 0; j < NA; j++) begin
        a = (m_cptr + j) % NA;
        if (g < 0 && m_busy[a] && m_t >= m_ready[a]) g = a;
      end
      for (int k = 0; k < NA; k++) fr[k] = !m_busy[k];
      if (g >= 0) begin
        e_cv = 1; e_calu = g; e_cidx = m_tag[g]; m_busy[g] = 0; m_cptr = (g + 1) % NA;
      end
      elig = rdy_vec & ~m_mask;
      m_mask = m_mask & rdy_vec;
      st = m_iptr;
      for (int j = 0; j < RS; j++) begin
        e = (st + j) % RS;
        if (elig[e]) begin
          a = -1;
          for (int k = 0; k < NA; k++) if (a < 0 && fr[k]) a = k;
          if (a >= 0) begin
            fr[a] = 0; e_iv[a] = 1'b1; e_idx[a] = e; e_op[a] = int'(rs_aluop[e]);
            m_busy[a] = 1; m_ready[a] = m_t + op_lat(e_op[a]) + 1; m_tag[a] = e;
            m_mask[e] = 1'b1; m_iptr = (e + 1) % RS;
          end
        end
      end
    end
    for (int k = 0; k < NA; k++) e_busy[k] = m_busy[k];
    m_t++;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    rdy_vec = '1;
    #1;
    n_cmp++; if (issue_valid !== 2'b00) begin n_bad++; $display("FAIL reset_async_iv: got %b want 00", issue_valid); end
    n_cmp++; if (alu_busy !== 2'b00 || cdb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_async_busy_cdb: got busy=%b cdb=%b want 00/0", alu_busy, cdb_valid); end
    n_cmp++; if (issue_idx !== '0 || cdb_idx !== '0 || cdb_alu !== '0 || issue_aluop !== '0) begin n_bad++; $display("FAIL reset_async_fields: got idx=%h cidx=%h calu=%h op=%h want 0", issue_idx, cdb_idx, cdb_alu, issue_aluop); end
    repeat (2) tick();
    n_cmp++; if (issue_valid !== 2'b00) begin n_bad++; $display("FAIL reset_held_iv: got %b want 00", issue_valid); end
    @(negedge clk);
    rst_n = 1'b1; rdy_vec = '0;
    tick();
    n_cmp++; if (alu_busy !== 2'b00 || cdb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_release: got busy=%b cdb=%b want 00/0", alu_busy, cdb_valid); end
  endtask

  task automatic test_pair_issue();
    apply_reset();
    rdy_vec = 8'b0000_0101;
    tick();
    rdy_vec = '0;
    n_cmp++; if (issue_valid !== 2'b11) begin n_bad++; $display("FAIL pair_iv: got %b want 11", issue_valid); end
    n_cmp++; if (issue_idx[0] !== 3'd0 || issue_idx[1] !== 3'd2) begin n_bad++; $display("FAIL pair_idx: got %0d,%0d want 0,2", issue_idx[0], issue_idx[1]); end
    n_cmp++; if (alu_busy !== 2'b11) begin n_bad++; $display("FAIL pair_busy: got %b want 11", alu_busy); end
    tick();
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL pair_cdb_early: got %b want 0", cdb_valid); end
    tick();
    n_cmp++; if ({cdb_valid, cdb_alu, cdb_idx} !== {1'b1, 1'b0, 3'd0}) begin n_bad++; $display("FAIL pair_cdb_first: got v=%b alu=%0d idx=%0d want 1/0/0", cdb_valid, cdb_alu, cdb_idx); end
    tick();
    n_cmp++; if ({cdb_valid, cdb_alu, cdb_idx} !== {1'b1, 1'b1, 3'd2}) begin n_bad++; $display("FAIL pair_cdb_second: got v=%b alu=%0d idx=%0d want 1/1/2", cdb_valid, cdb_alu, cdb_idx); end
    tick();
    n_cmp++; if (cdb_valid !== 1'b0 || alu_busy !== 2'b00) begin n_bad++; $display("FAIL pair_drain: got cdb=%b busy=%b want 0/00", cdb_valid, alu_busy); end
  endtask

  task automatic test_exp_latency();
    int t_iss, t0, t1, busy_cnt;
    apply_reset();
    t0 = -1; t1 = -1;
    rdy_vec = 8'b0000_0011; rs_aluop[0] = 3'b111; rs_aluop[1] = 3'b000;
    tick();
    t_iss = cyc; rdy_vec = '0;
    busy_cnt = int'(alu_busy[0]);
    n_cmp++; if (issue_valid !== 2'b11 || issue_aluop[0] !== 3'b111) begin n_bad++; $display("FAIL exp_issue: got iv=%b op0=%b want 11/111", issue_valid, issue_aluop[0]); end
    repeat (14) begin
      tick();
      busy_cnt += int'(alu_busy[0]);
      if (cdb_valid && cdb_idx == 3'd0) t0 = cyc;
      if (cdb_valid && cdb_idx == 3'd1) t1 = cyc;
    end
    n_cmp++; if (t1 - t_iss !== 2) begin n_bad++; $display("FAIL exp_fast_cdb: got %0d want 2 cycles after issue", t1 - t_iss); end
    n_cmp++; if (t0 - t1 !== 7) begin n_bad++; $display("FAIL exp_gap: got %0d want 7", t0 - t1); end
    n_cmp++; if (busy_cnt !== 9) begin n_bad++; $display("FAIL exp_busy_cycles: got %0d want 9", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    rdy_vec = 8'hFF;
    tick();
    n_cmp++; if (issue_valid !== 2'b11) begin n_bad++; $display("FAIL b2b_first_pair: got %b want 11", issue_valid); end
    repeat (39) tick();
    n_cmp++; if (iss_log.size() !== 8) begin n_bad++; $display("FAIL b2b_count: got %0d want 8", iss_log.size()); end
    for (int i = 0; i < 8 && i < iss_log.size(); i++) begin
      n_cmp++; if (iss_log[i] !== i) begin n_bad++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, iss_log[i], i); end
    end
    rdy_vec[3] = 1'b0;
    tick();
    rdy_vec[3] = 1'b1;
    repeat (6) tick();
    n_cmp++; if (iss_log.size() !== 9 || iss_log[iss_log.size()-1] !== 3) begin n_bad++; $display("FAIL b2b_reissue: got n=%0d last=%0d want 9/3", iss_log.size(), iss_log[iss_log.size()-1]); end
    n_cmp++; if (cdb_log.size() !== 9) begin n_bad++; $display("FAIL b2b_results: got %0d want 9", cdb_log.size()); end
  endtask

  task automatic test_cdb_contention();
    int exp_log[5];
    exp_log = '{0*16+0, 1*16+1, 0*16+2, 1*16+4, 0*16+3};
    apply_reset();
    rdy_vec = 8'b0000_0011; tick(); rdy_vec = '0; repeat (4) tick();
    rdy_vec = 8'b0000_0100; tick(); rdy_vec = '0; repeat (3) tick();
    rdy_vec = 8'b0001_1000; tick(); rdy_vec = '0; repeat (4) tick();
    n_cmp++; if (cdb_log.size() !== 5) begin n_bad++; $display("FAIL cdb_rr_count: got %0d want 5", cdb_log.size()); end
    for (int i = 0; i < 5 && i < cdb_log.size(); i++) begin
      n_cmp++; if (cdb_log[i] !== exp_log[i]) begin n_bad++; $display("FAIL cdb_rr[%0d]: got alu%0d/idx%0d want alu%0d/idx%0d", i, cdb_log[i]/16, cdb_log[i]%16, exp_log[i]/16, exp_log[i]%16); end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    rdy_vec = 8'b0000_0011; rs_aluop[0] = 3'b101; rs_aluop[1] = 3'b000;
    tick();
    rdy_vec = '0;
    tick();
    n_cmp++; if (alu_busy !== 2'b11 || cdb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_pre: got busy=%b cdb=%b want 11/0", alu_busy, cdb_valid); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (alu_busy !== 2'b00 || cdb_valid !== 1'b0 || issue_valid !== 2'b00) begin n_bad++; $display("FAIL flush_post: got busy=%b cdb=%b iv=%b want 00/0/00", alu_busy, cdb_valid, issue_valid); end
    repeat (12) tick();
    n_cmp++; if (cdb_log.size() !== 0) begin n_bad++; $display("FAIL flush_no_result: got %0d broadcasts want 0", cdb_log.size()); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    rdy_vec = 8'b0010_0000; rs_aluop[5] = 3'b111;
    tick();
    rdy_vec = '0;
    repeat (2) tick();
    n_cmp++; if (alu_busy !== 2'b01) begin n_bad++; $display("FAIL arst_pre_busy: got %b want 01", alu_busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (alu_busy !== 2'b00 || issue_valid !== 2'b00 || cdb_valid !== 1'b0) begin n_bad++; $display("FAIL arst_immediate: got busy=%b iv=%b cdb=%b want 0", alu_busy, issue_valid, cdb_valid); end
    @(negedge clk);
    rst_n = 1'b1; rdy_vec = 8'b1110_0001; rs_aluop = '0;
    tick();
    n_cmp++; if (issue_valid !== 2'b11 || issue_idx[0] !== 3'd0 || issue_idx[1] !== 3'd5) begin n_bad++; $display("FAIL arst_restart: got iv=%b idx=%0d,%0d want 11 0,5", issue_valid, issue_idx[0], issue_idx[1]); end
    rdy_vec = '0;
  endtask

  task automatic test_random();
    apply_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < RS; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          rdy_vec[i]  = ~rdy_vec[i];
          rs_aluop[i] = 3'($urandom_range(0, 7));
        end
      end
      flush = ($urandom_range(0, 63) == 0);
      model_edge();
      tick();
      n_cmp++; if (issue_valid !== e_iv) begin n_bad++; $display("FAIL rnd_iv @%0d: got %b want %b", cyc, issue_valid, e_iv); end
      for (int k = 0; k < NA; k++) begin
        if (e_iv[k]) begin
          n_cmp++; if (issue_idx[k] !== 3'(e_idx[k]) || issue_aluop[k] !== 3'(e_op[k])) begin n_bad++; $display("FAIL rnd_issue%0d @%0d: got idx=%0d op=%0d want idx=%0d op=%0d", k, cyc, issue_idx[k], issue_aluop[k], e_idx[k], e_op[k]); end
        end
      end
      n_cmp++; if (alu_busy !== e_busy) begin n_bad++; $display("FAIL rnd_busy @%0d: got %b want %b", cyc, alu_busy, e_busy); end
      n_cmp++; if (cdb_valid !== e_cv) begin n_bad++; $display("FAIL rnd_cdb_valid @%0d: got %b want %b", cyc, cdb_valid, e_cv); end
      if (e_cv) begin
        n_cmp++; if (cdb_alu !== 1'(e_calu) || cdb_idx !== 3'(e_cidx)) begin n_bad++; $display("FAIL rnd_cdb @%0d: got alu=%0d idx=%0d want alu=%0d idx=%0d", cyc, cdb_alu, cdb_idx, e_calu, e_cidx); end
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pair_issue();
    test_exp_latency();
    test_back_to_back();
    test_cdb_contention();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
